mult_issuer: RTL and testbench

MULT_ISSUER -- requirements
Module: mult_issuer

---
 rtl/mult_issuer.sv | 144 ++++++++++++++
 tb/tb_mult_issuer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issuer.sv
// mult_issuer: queues operand pairs in a small FIFO and feeds them, one at a
// time, to a downstream sequential multiplier using a start/ready handshake.
// The product is held on out_product until the consumer accepts it.
//
// Optional build macro: MULT_ISSUER_COUNT_EN
//   defined   -> op_count counts accepted results (wraps at 2^16)
//   undefined -> op_count is tied to 0 and no counter register exists
module mult_issuer #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           mul_start,
  output logic [N-1:0]   mul_multiplicand,
  output logic [N-1:0]   mul_multiplier,
  input  logic           mul_ready,
  input  logic [2*N-1:0] mul_product,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_product,
  output logic [15:0]    op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] mem_q [DEPTH];
  logic           head_avail_q;  // FIFO was non-empty on the previous cycle
  logic           alive_q;       // low only until the first edge after reset
  logic           wait_seen_q;   // previous cycle was already WAIT
  logic [N-1:0]   opa_q, opb_q;
  logic [2*N-1:0] product_q;

  logic push, pop, capture, release_res, fifo_empty, fifo_full;
  logic [N-1:0] head_a, head_b;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == FULL_COUNT);
  assign in_ready    = alive_q && !fifo_full;
  assign push        = in_valid && in_ready;
  // The FSM pops only once the entry has been visible for a full cycle, so a
  // freshly written pair never races straight through to the operand regs.
  assign pop         = (state_q == ST_IDLE) && head_avail_q && !fifo_empty;
  // The first WAIT cycle still sees the ready level left from the previous
  // operation, so mul_ready is only trusted from the second WAIT cycle on.
  assign capture     = (state_q == ST_WAIT) && wait_seen_q && mul_ready;
  assign release_res = (state_q == ST_HOLD) && out_ready;
  assign {head_a, head_b} = mem_q[rd_ptr_q];

  // Next-state logic for the issue FSM and the FIFO bookkeeping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (capture) state_d = ST_HOLD;
      ST_HOLD:  if (release_res) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FIFO storage: written on push, deliberately not reset.
  always_ff @(posedge clock) begin
    // NOTE: storage needs no reset; an empty count makes stale contents
    // unreachable, and leaving it out keeps the array plain RAM.
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  // Control, operand and result registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_avail_q <= 1'b0;
      alive_q      <= 1'b0;
      wait_seen_q  <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      product_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_avail_q <= !fifo_empty;
      alive_q      <= 1'b1;
      wait_seen_q  <= (state_q == ST_WAIT);
      if (pop) begin
        opa_q <= head_a;
        opb_q <= head_b;
      end
      if (capture) product_q <= mul_product;
    end
  end

  assign mul_start        = (state_q == ST_ISSUE);
  assign out_valid        = (state_q == ST_HOLD);
  assign mul_multiplicand = opa_q;
  assign mul_multiplier   = opb_q;
  assign out_product      = product_q;

`ifdef MULT_ISSUER_COUNT_EN
  logic [15:0] op_count_q;

  // Completed-result counter, stepped on every accepted result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         op_count_q <= '0;
    else if (release_res) op_count_q <= op_count_q + 16'd1;
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'd0;
`endif

endmodule

// File: tb/tb_mult_issuer.sv
// Directed bench for mult_issuer with a behavioural sequential multiplier.
module tb_mult_issuer;
  localparam int N = 4;
  localparam int DEPTH = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a, in_b;
  logic           mul_start;
  logic [N-1:0]   mul_multiplicand, mul_multiplier;
  logic           mul_ready;
  logic [2*N-1:0] mul_product;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;
  logic [15:0]    op_count;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;

  mult_issuer #(.N(N), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
    .mul_multiplier(mul_multiplier), .mul_ready(mul_ready),
    .mul_product(mul_product), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // Behavioural multiplier: ready level rises three edges after start is sampled.
  int mcnt;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mul_ready   <= 1'b0;
      mcnt        <= 0;
      mul_product <= '0;
    end else if (mul_start) begin
      mul_ready   <= 1'b0;
      mcnt        <= N - 1;
      mul_product <= {{N{1'b0}}, mul_multiplicand} * {{N{1'b0}}, mul_multiplier};
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_ready <= 1'b1;
    end
  end

  always @(posedge clock) if (mul_start) start_cnt <= start_cnt + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int a, input int b);
    in_a = N'(a);
    in_b = N'(b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++;
      if (mul_start !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mul_start cycle %0d: got %b want 0", i, mul_start);
      end
    end
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags: in_ready/out_valid got %b want 00", {in_ready, out_valid});
    end
    n_cmp++;
    if ({mul_multiplicand, mul_multiplier, out_product} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got a=%0d b=%0d p=%0d want 0", mul_multiplicand, mul_multiplier, out_product);
    end
    n_cmp++;
    if (op_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_op_count: got %0d want 0", op_count);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    int ms_first = 0, ms_cnt = 0, ov_first = 0;
    logic [2*N-1:0] prod = '0;
    logic [N-1:0] oa = '0, ob = '0;
    out_ready = 1'b1;
    push(11, 6);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (mul_start === 1'b1) begin
        ms_cnt++;
        if (ms_first == 0) begin
          ms_first = k; oa = mul_multiplicand; ob = mul_multiplier;
        end
      end
      if (out_valid === 1'b1 && ov_first == 0) begin
        ov_first = k; prod = out_product;
      end
    end
    n_cmp++;
    if (ms_first !== 2) begin n_err++; $display("FAIL lat_start_edge: got %0d want 2", ms_first); end
    n_cmp++;
    if (ms_cnt !== 1) begin n_err++; $display("FAIL lat_start_width: got %0d want 1", ms_cnt); end
    n_cmp++;
    if (oa !== 4'd11 || ob !== 4'd6) begin
      n_err++; $display("FAIL lat_operands: got %0d,%0d want 11,6", oa, ob);
    end
    n_cmp++;
    if (ov_first !== 7) begin n_err++; $display("FAIL lat_valid_edge: got %0d want 7", ov_first); end
    n_cmp++;
    if (prod !== 8'd66) begin n_err++; $display("FAIL lat_product: got %0d want 66", prod); end
  endtask

  // Leaves the FSM parked in HOLD with product 130 and out_ready low.
  task automatic test_hold_stall();
    int s0;
    bit seen = 0;
    out_ready = 1'b0;
    push(13, 10);
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (out_valid === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL hold_timeout: out_valid got 0 want 1"); end
    s0 = start_cnt;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_product !== 8'd130) begin
        n_err++;
        $display("FAIL hold_stable cycle %0d: got v=%b p=%0d want v=1 p=130", k, out_valid, out_product);
      end
    end
    n_cmp++;
    if (start_cnt !== s0) begin
      n_err++; $display("FAIL hold_no_start: got %0d starts want 0", start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    int pa[5] = '{1, 3, 5, 7, 9};
    int pb[5] = '{2, 4, 6, 8, 10};
    int exp_p[6] = '{130, 2, 12, 30, 56, 90};
    int r = 0;
    logic acc_in, acc_out;
    logic [2*N-1:0] got;
    for (int i = 0; i < 4; i++) begin
      in_a = N'(pa[i]); in_b = N'(pb[i]); in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready_before_push %0d: got %b want 1", i, in_ready);
      end
      tick();
    end
    in_a = N'(pa[4]); in_b = N'(pb[4]);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_full: in_ready got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 200 && r < 6; c++) begin
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      got     = out_product;
      tick();
      if (acc_in) in_valid = 1'b0;
      if (acc_out) begin
        n_cmp++;
        if (got !== 8'(exp_p[r])) begin
          n_err++; $display("FAIL b2b_order result %0d: got %0d want %0d", r, got, exp_p[r]);
        end
        r++;
      end
    end
    n_cmp++;
    if (r !== 6) begin n_err++; $display("FAIL b2b_timeout: got %0d results want 6", r); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bit seen = 0, saw_valid = 0, saw_225 = 0;
    int s0;
    out_ready = 1'b1;
    push(2, 2);
    push(15, 15);
    for (int k = 0; k < 10 && !seen; k++) begin
      if (mul_start === 1'b1) seen = 1;
      else tick();
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rst_mid_timeout: mul_start got 0 want 1"); end
    tick();  // first WAIT cycle
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, mul_start, out_valid} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_flags: got %b want 000", {in_ready, mul_start, out_valid});
    end
    n_cmp++;
    if ({mul_multiplicand, mul_multiplier, out_product} !== '0 || op_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_mid_data: got a=%0d b=%0d p=%0d cnt=%0d want 0", mul_multiplicand, mul_multiplier, out_product, op_count);
    end
    tick(); tick();
    reset_n = 1'b1;
    s0 = start_cnt;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (out_valid === 1'b1) saw_valid = 1;
      if (out_product === 8'd225) saw_225 = 1;
    end
    n_cmp++;
    if (saw_valid || saw_225) begin
      n_err++; $display("FAIL rst_mid_discard: got valid=%b p225=%b want 0 0", saw_valid, saw_225);
    end
    n_cmp++;
    if (start_cnt !== s0) begin
      n_err++; $display("FAIL rst_mid_no_start: got %0d starts want 0", start_cnt - s0);
    end
  endtask

  task automatic test_op_count();
    int exp_p[3] = '{9, 10, 16};
    int r = 0;
    logic [15:0] exp_cnt;
    logic [2*N-1:0] got;
    logic acc_out;
`ifdef MULT_ISSUER_COUNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    out_ready = 1'b1;
    push(3, 3);
    push(2, 5);
    push(4, 4);
    for (int c = 0; c < 80 && r < 3; c++) begin
      acc_out = out_valid && out_ready;
      got = out_product;
      tick();
      if (acc_out) begin
        n_cmp++;
        if (got !== 8'(exp_p[r])) begin
          n_err++; $display("FAIL cnt_result %0d: got %0d want %0d", r, got, exp_p[r]);
        end
        r++;
      end
    end
    tick();
    n_cmp++;
    if (r !== 3) begin n_err++; $display("FAIL cnt_timeout: got %0d results want 3", r); end
    n_cmp++;
    if (op_count !== exp_cnt) begin
      n_err++; $display("FAIL op_count: got %0d want %0d", op_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid_op();
    test_op_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
